neuron_scheduler: RTL and testbench

NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

---
 rtl/snn_ctrl_pkg.sv | 24 ++
 rtl/neuron_scheduler_if.sv | 39 +++
 rtl/neuron_scheduler_cycle_counter.sv | 42 ++++
 rtl/neuron_scheduler.sv | 122 ++++++++++++
 tb/tb_neuron_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared scheduler types: FSM state encoding and group-select width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_ctrl_pkg;

    localparam int GRP_W = 6;
    localparam int CNT_W = 8;

    typedef logic [GRP_W-1:0] grp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // True while a group is being worked on (LOAD, ACCUM or STORE).
    function automatic logic in_group(input sched_state_t s);
        return (s == ST_LOAD) || (s == ST_ACCUM) || (s == ST_STORE);
    endfunction

endpackage

// File: rtl/neuron_scheduler_if.sv
// Control/handshake bundle between the neuron scheduler and its surroundings.
// Latency: n/a (wires only).
// Backpressure: mem_wr_ready stalls the scheduler in its write-back phase.
interface neuron_scheduler_if;
    import snn_ctrl_pkg::*;

    logic start;
    logic layer_sel;
    logic abort;
    logic mem_wr_ready;

    logic busy;
    logic done;
    grp_t cntrl_potential_in_sel;
    grp_t cntrl_potential_out_sel;
    logic cntrl_spk_select;
    logic mem_rd_en;
    grp_t mem_rd_addr;
    logic mem_wr_en;
    grp_t mem_wr_addr;
    logic acc_en;

    // Scheduler side.
    modport slave (
        input  start, layer_sel, abort, mem_wr_ready,
        output busy, done, cntrl_potential_in_sel, cntrl_potential_out_sel,
               cntrl_spk_select, mem_rd_en, mem_rd_addr, mem_wr_en,
               mem_wr_addr, acc_en
    );

    // Controller / memory side.
    modport master (
        output start, layer_sel, abort, mem_wr_ready,
        input  busy, done, cntrl_potential_in_sel, cntrl_potential_out_sel,
               cntrl_spk_select, mem_rd_en, mem_rd_addr, mem_wr_en,
               mem_wr_addr, acc_en
    );

endinterface

// File: rtl/neuron_scheduler_cycle_counter.sv
// Cycle counter with synchronous clear, enable and terminal-count flag.
// Latency: tc_o is a registered-count decode, high on the ACC_CYCLES-th enabled cycle.
// Backpressure: none; counts whenever en_i is high.
module neuron_scheduler_cycle_counter
    import snn_ctrl_pkg::*;
#(
    parameter int ACC_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority so the count always restarts at zero on entry.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/neuron_scheduler.sv
// Layer-pass sequencer: per group LOAD (1) -> ACCUM (ACC_CYCLES) -> STORE (>=1), then DONE.
// Latency: 1 + N_GROUPS*(ACC_CYCLES+2) busy cycles per unstalled pass; outputs registered.
// Backpressure: mem_wr_ready=0 holds STORE with no write; abort ends the pass within one cycle.
module neuron_scheduler
    import snn_ctrl_pkg::*;
#(
    parameter int N_GROUPS   = 64,
    parameter int ACC_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    neuron_scheduler_if.slave   sched_if
);

    localparam grp_t LAST_G = grp_t'(N_GROUPS - 1);

    sched_state_t state_q, state_d;
    grp_t         g_q, g_d;
    logic         lyr_q, lyr_d;
    logic         acc_tc;

    logic busy_q, done_q, spk_q, rd_en_q, acc_en_q;
    grp_t in_sel_q, out_sel_q, rd_addr_q, wr_addr_q;

    neuron_scheduler_cycle_counter #(
        .ACC_CYCLES (ACC_CYCLES)
    ) u_acc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == ST_LOAD),
        .en_i  (state_q == ST_ACCUM),
        .tc_o  (acc_tc)
    );

    // Next-state, group counter and latched layer select; abort beats mem_wr_ready.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        lyr_d   = lyr_q;
        case (state_q)
            ST_IDLE: begin
                if (sched_if.start) begin
                    state_d = ST_LOAD;
                    g_d     = '0;
                    lyr_d   = sched_if.layer_sel;
                end
            end
            ST_LOAD: begin
                state_d = sched_if.abort ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (sched_if.abort) begin
                    state_d = ST_DONE;
                end else if (acc_tc) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                if (sched_if.abort) begin
                    state_d = ST_DONE;
                end else if (sched_if.mem_wr_ready) begin
                    if (g_q == LAST_G) begin
                        state_d = ST_DONE;
                    end else begin
                        g_d     = g_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers plus outputs pre-decoded from the next state so they launch from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            g_q       <= '0;
            lyr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spk_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            acc_en_q  <= 1'b0;
            in_sel_q  <= '0;
            out_sel_q <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            lyr_q     <= lyr_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            spk_q     <= (state_d != ST_IDLE) ? lyr_d : 1'b0;
            rd_en_q   <= (state_d == ST_LOAD);
            acc_en_q  <= (state_d == ST_ACCUM);
            in_sel_q  <= in_group(state_d) ? g_d : '0;
            out_sel_q <= (state_d == ST_STORE) ? g_d : '0;
            rd_addr_q <= (state_d == ST_LOAD) ? g_d : '0;
            wr_addr_q <= (state_d == ST_STORE) ? g_d : '0;
        end
    end

    assign sched_if.busy                    = busy_q;
    assign sched_if.done                    = done_q;
    assign sched_if.cntrl_spk_select        = spk_q;
    assign sched_if.mem_rd_en               = rd_en_q;
    assign sched_if.acc_en                  = acc_en_q;
    assign sched_if.cntrl_potential_in_sel  = in_sel_q;
    assign sched_if.cntrl_potential_out_sel = out_sel_q;
    assign sched_if.mem_rd_addr             = rd_addr_q;
    assign sched_if.mem_wr_addr             = wr_addr_q;
    // The only input-to-output path: the write strobe follows ready, suppressed by abort.
    assign sched_if.mem_wr_en = (state_q == ST_STORE) && sched_if.mem_wr_ready && !sched_if.abort;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Self-checking bench for neuron_scheduler: directed pass table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: mem_wr_ready stalls driven from the table and at random.
module tb_neuron_scheduler;
    import snn_ctrl_pkg::*;

    localparam int SN = 4;
    localparam int SA = 3;
    localparam int GL = SA + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    neuron_scheduler_if ifs ();
    neuron_scheduler_if ifd ();

    neuron_scheduler #(.N_GROUPS(SN), .ACC_CYCLES(SA)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (ifs.slave)
    );

    neuron_scheduler dut_d (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (ifd.slave)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] obs_s();
        return {ifs.busy, ifs.done, ifs.cntrl_spk_select, ifs.mem_rd_en, ifs.acc_en,
                ifs.mem_wr_en, ifs.cntrl_potential_in_sel, ifs.cntrl_potential_out_sel,
                ifs.mem_rd_addr, ifs.mem_wr_addr};
    endfunction

    // Reference model: mode 0 idle, 1 in pass, 2 done pulse; within a pass the
    // position is (group m_g, offset m_off) with offset 0 = read, 1..SA = accumulate, SA+1 = write-back.
    int   m_mode = 0;
    int   m_g    = 0;
    int   m_off  = 0;
    logic m_lyr  = 1'b0;

    function automatic logic [29:0] model_exp(input logic rdy, input logic ab);
        logic ld, acc, st;
        grp_t g;
        g   = grp_t'(m_g);
        ld  = (m_mode == 1) && (m_off == 0);
        acc = (m_mode == 1) && (m_off >= 1) && (m_off <= SA);
        st  = (m_mode == 1) && (m_off == SA + 1);
        return {(m_mode != 0), (m_mode == 2), ((m_mode != 0) && m_lyr), ld, acc,
                (st && rdy && !ab),
                ((m_mode == 1) ? g : grp_t'(0)), (st ? g : grp_t'(0)),
                (ld ? g : grp_t'(0)), (st ? g : grp_t'(0))};
    endfunction

    task automatic model_step();
        if (m_mode == 0) begin
            if (ifs.start) begin
                m_mode = 1; m_g = 0; m_off = 0; m_lyr = ifs.layer_sel;
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else if (ifs.abort) begin
            m_mode = 2;
        end else if (m_off < SA + 1) begin
            m_off++;
        end else if (ifs.mem_wr_ready) begin
            if (m_g == SN - 1) m_mode = 2;
            else begin m_g++; m_off = 0; end
        end
    endtask

    // Per-cycle comparison of the small instance against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_g = 0; m_off = 0; m_lyr = 1'b0;
            if (chk_on) check("reset_outputs", 64'(obs_s()), 64'd0);
        end else if (chk_on) begin
            check("model_cycle", 64'(obs_s()), 64'(model_exp(ifs.mem_wr_ready, ifs.abort)));
            model_step();
        end
    end

    typedef struct {
        logic lyr;
        int   stall_g;
        int   stall_n;
        int   abort_g;
        int   abort_off;
        int   exp_busy;
        int   exp_writes;
        int   exp_acc;
    } vec_t;

    vec_t vecs[6];

    task automatic run_pass(input vec_t v, input int idx);
        int k, nb, nd, done_at, nw, addr_err, nacc, spk_err, sc, ac;
        bit ended;
        nb = 0; nd = 0; done_at = -1; nw = 0; addr_err = 0; nacc = 0; spk_err = 0; ended = 0;
        sc = (v.stall_n > 0) ? v.stall_g * GL + GL : -1;
        ac = (v.abort_g >= 0) ? v.abort_g * GL + v.abort_off + 1 : -1;
        @(posedge clk); #2;
        ifs.start = 1'b1; ifs.layer_sel = v.lyr; ifs.abort = 1'b0; ifs.mem_wr_ready = 1'b1;
        @(posedge clk); #2;
        ifs.start = 1'b0; ifs.layer_sel = ~v.lyr;
        k = 1;
        while (k < 200) begin
            ifs.mem_wr_ready = !(sc > 0 && k >= sc && k < sc + v.stall_n);
            ifs.abort        = (k == ac);
            @(negedge clk);
            if (!ifs.busy) begin ended = 1; break; end
            nb++;
            if (ifs.done) begin nd++; done_at = k; end
            if (ifs.mem_wr_en) begin
                if (ifs.mem_wr_addr != grp_t'(nw)) addr_err++;
                nw++;
            end
            if (ifs.acc_en) nacc++;
            if (ifs.cntrl_spk_select != v.lyr) spk_err++;
            @(posedge clk); #2;
            k++;
        end
        ifs.abort = 1'b0; ifs.mem_wr_ready = 1'b1;
        check($sformatf("v%0d_terminated", idx), 64'(ended), 64'd1);
        check($sformatf("v%0d_busy_cycles", idx), 64'(nb), 64'(v.exp_busy));
        check($sformatf("v%0d_done_count", idx), 64'(nd), 64'd1);
        check($sformatf("v%0d_done_at", idx), 64'(done_at), 64'(v.exp_busy));
        check($sformatf("v%0d_writes", idx), 64'(nw), 64'(v.exp_writes));
        check($sformatf("v%0d_addr_order_err", idx), 64'(addr_err), 64'd0);
        check($sformatf("v%0d_acc_cycles", idx), 64'(nacc), 64'(v.exp_acc));
        check($sformatf("v%0d_spk_err", idx), 64'(spk_err), 64'd0);
    endtask

    initial begin
        int k, nd, nb, nw, last, mx, done_at, spk_err, idle_cnt;
        logic prev_busy, prev_ls, acc_lyr;

        //        lyr   sg  sn  ag  aoff busy wr acc
        vecs[0] = '{1'b1, 0, 0, -1, 0,  21,  4, 12};
        vecs[1] = '{1'b0, 2, 5, -1, 0,  26,  4, 12};
        vecs[2] = '{1'b1, 0, 0,  1, 2,   9,  1,  5};
        vecs[3] = '{1'b0, 0, 1, -1, 0,  22,  4, 12};
        vecs[4] = '{1'b1, 0, 0,  3, 4,  21,  3, 12};
        vecs[5] = '{1'b0, 0, 0,  0, 0,   2,  0,  0};

        ifs.start = 0; ifs.layer_sel = 0; ifs.abort = 0; ifs.mem_wr_ready = 1;
        ifd.start = 0; ifd.layer_sel = 0; ifd.abort = 0; ifd.mem_wr_ready = 1;
        rst_n  = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed pass table.
        for (int i = 0; i < 6; i++) run_pass(vecs[i], i);

        // Asynchronous reset during the write-back of the last group.
        @(posedge clk); #2 ifs.start = 1'b1; ifs.layer_sel = 1'b1;
        @(posedge clk); #2 ifs.start = 1'b0;
        for (int c = 1; c < 4 * GL; c++) begin @(posedge clk); #2; end
        check("rst_pre_out_sel", 64'(ifs.cntrl_potential_out_sel), 64'd3);
        rst_n = 1'b0;
        #1 check("rst_async_outputs", 64'(obs_s()), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        nd = 0; nb = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifs.done) nd++;
            if (ifs.busy) nb++;
        end
        check("rst_no_done", 64'(nd), 64'd0);
        check("rst_stays_idle", 64'(nb), 64'd0);

        // start held high, layer_sel toggling every cycle: back-to-back passes.
        @(posedge clk); #2 ifs.start = 1'b1; ifs.layer_sel = 1'b0;
        prev_busy = 1'b0; prev_ls = 1'b0; acc_lyr = 1'b0;
        nd = 0; spk_err = 0; idle_cnt = 0; k = 0;
        while (k < 300) begin
            @(negedge clk);
            if (ifs.busy && !prev_busy) begin
                acc_lyr = prev_ls;
                if (nd > 0) check($sformatf("hold_gap%0d", nd), 64'(idle_cnt), 64'd1);
            end
            if (ifs.busy && ifs.cntrl_spk_select != acc_lyr) spk_err++;
            if (!ifs.busy) idle_cnt++;
            if (ifs.done) begin nd++; idle_cnt = 0; end
            prev_busy = ifs.busy;
            prev_ls   = ifs.layer_sel;
            if (nd == 3) break;
            @(posedge clk); #2 ifs.layer_sel = ~ifs.layer_sel;
            k++;
        end
        @(posedge clk); #2 ifs.start = 1'b0;
        check("hold_done_count", 64'(nd), 64'd3);
        check("hold_spk_err", 64'(spk_err), 64'd0);
        @(negedge clk);

        // Default-size instance: one unstalled pass.
        @(posedge clk); #2 ifd.start = 1'b1; ifd.layer_sel = 1'b1;
        @(posedge clk); #2 ifd.start = 1'b0;
        nb = 0; nw = 0; last = -1; mx = 0; done_at = -1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!ifd.busy) break;
            nb++;
            if (ifd.done) done_at = nb;
            if (ifd.mem_wr_en) begin nw++; last = int'(ifd.mem_wr_addr); end
            if (int'(ifd.cntrl_potential_in_sel)  > mx) mx = int'(ifd.cntrl_potential_in_sel);
            if (int'(ifd.cntrl_potential_out_sel) > mx) mx = int'(ifd.cntrl_potential_out_sel);
            if (int'(ifd.mem_rd_addr)             > mx) mx = int'(ifd.mem_rd_addr);
        end
        check("dflt_busy_cycles", 64'(nb), 64'd1153);
        check("dflt_done_at", 64'(done_at), 64'd1153);
        check("dflt_writes", 64'(nw), 64'd64);
        check("dflt_last_addr", 64'(last), 64'd63);
        check("dflt_max_sel", 64'(mx), 64'd63);

        // Random traffic on the small instance, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            ifs.start        = ($urandom_range(0, 3) == 0);
            ifs.layer_sel    = 1'($urandom_range(0, 1));
            ifs.abort        = ($urandom_range(0, 39) == 0);
            ifs.mem_wr_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #2;
        ifs.start = 0; ifs.abort = 0; ifs.mem_wr_ready = 1;
        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
